prog_loader: RTL and testbench

Byte-serial program loader sitting directly upstream of the 8-bit CPU core. It receives a framed program image over a valid/ready byte stream and assembles 16-bit instruction words, high byte first. It writes the words sequentially into instruction memory from address 0 and holds the CPU in reset until a complete, checked image is in place. On success it releases the CPU. On timeout or checksum failure it keeps the CPU in reset and reports an error code.

---
 rtl/prog_loader_if.sv | 16 +
 rtl/prog_loader.sv | 96 +++++++++
 tb/tb_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and instruction-memory write port of the program loader.
//   rx_data/rx_valid/rx_ready : valid/ready byte stream toward the loader
//   imem_we/imem_addr/imem_wdata : registered instruction-memory write port from the loader
//   Modport master is the byte source and memory side; modport slave is the loader.
interface prog_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0] rx_data;
   logic rx_valid;
   logic rx_ready;
   logic imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0] imem_wdata;
   modport master (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
   modport slave (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: byte-serial loader that writes a framed program image into instruction memory
//   and holds the CPU in reset until the image is complete and checked.
//   Frame: SYNC_BYTE, LEN, LEN words as hi/lo byte pairs (LEN = 0 means 2^ADDR_W words),
//   then a CSUM byte (XOR of LEN and all data bytes) when LOADER_CHECKSUM_EN is defined.
//   Ports: clk, rst (synchronous, active high)
//          bus       prog_loader_if.slave: byte stream in, memory write port out
//          cpu_rst   high while the CPU is held in reset
//          load_done image loaded and accepted
//          load_err  frame aborted
//          err_code  01 inter-byte timeout, 10 checksum mismatch, 00 none
module prog_loader #(
   parameter int ADDR_W = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input logic clk,
   input logic rst,
   prog_loader_if.slave bus,
   output logic cpu_rst,
   output logic load_done,
   output logic load_err,
   output logic [1:0] err_code
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CSUM, DONE, ERR} state_t;
   logic [7:0] acc;
`else
   typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, DONE, ERR} state_t;
`endif
   state_t state, next;
   logic [ADDR_W-1:0] count;
   logic [7:0] hi;
   logic [TW-1:0] cnt;
   logic xfer, sync, timing, timeout, last;
   assign bus.rx_ready = !rst && state != WR;
   assign xfer = bus.rx_valid && bus.rx_ready;
   assign sync = xfer && bus.rx_data == SYNC_BYTE;
   assign timing = !(state inside {IDLE, WR, DONE, ERR});
   // a byte arriving on the terminal count wins over the timeout
   assign timeout = timing && !xfer && cnt == TW'(TIMEOUT_CYCLES - 1);
   // count is LEN truncated to the address width, so LEN = 0 ends on the all-ones address
   assign last = bus.imem_addr == count - ADDR_W'(1);
   assign cpu_rst = state != DONE;
   assign load_done = state == DONE;
   assign load_err = state == ERR;
   always_ff @(posedge clk) state <= rst ? IDLE : next;
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE, ERR: next = sync ? LEN : state;
         LEN: next = xfer ? HI : LEN;
         HI: next = xfer ? LO : HI;
         LO: next = xfer ? WR : LO;
`ifdef LOADER_CHECKSUM_EN
         WR: next = last ? CSUM : HI;
         CSUM: next = !xfer ? CSUM : bus.rx_data == acc ? DONE : ERR;
`else
         WR: next = last ? DONE : HI;
`endif
         default: next = IDLE;
      endcase
      if (timeout) next = ERR;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         count <= '0;
         hi <= '0;
         bus.imem_we <= 1'b0;
         bus.imem_addr <= '0;
         bus.imem_wdata <= '0;
         err_code <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
         acc <= '0;
`endif
      end else begin
         cnt <= (xfer || !timing) ? '0 : cnt + TW'(1);
         bus.imem_we <= state == LO && xfer;
         if (state == LEN && xfer) begin
            count <= ADDR_W'(bus.rx_data);
            bus.imem_addr <= '0;
         end
         if (state == HI && xfer) hi <= bus.rx_data;
         if (state == LO && xfer) bus.imem_wdata <= {hi, bus.rx_data};
         if (state == WR) bus.imem_addr <= bus.imem_addr + ADDR_W'(1);
         // entering ERR from a frame is either a timeout or a checksum mismatch
         if (next == ERR && state != ERR) err_code <= timeout ? 2'b01 : 2'b10;
         else if (state == ERR && sync) err_code <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
         if (state == LEN && xfer) acc <= bus.rx_data;
         else if ((state == HI || state == LO) && xfer) acc <= acc ^ bus.rx_data;
`endif
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader; a frame-level model gives
//   the expected memory writes and the final {cpu_rst, load_done, load_err, err_code} status.
module tb_prog_loader;
   localparam int ADDR_W = 8;
   localparam int TIMEOUT_CYCLES = 1024;
   localparam logic [7:0] SYNC = 8'hA5;
   localparam logic [4:0] HELD = 5'b10000;
   localparam logic [4:0] DONE = 5'b01000;
   localparam logic [4:0] ERR_TO = 5'b10101;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [4:0] ERR_CS = 5'b10110;
   logic [7:0] csum;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cpu_rst, load_done, load_err;
   logic [1:0] err_code;
   logic [4:0] st;
   int checks = 0;
   int errors = 0;
   logic [15:0] words [256];
   logic [ADDR_W+15:0] wq [$];
   prog_loader_if #(.ADDR_W(ADDR_W)) bus ();
   prog_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave), .cpu_rst(cpu_rst),
      .load_done(load_done), .load_err(load_err), .err_code(err_code)
   );
   assign st = {cpu_rst, load_done, load_err, err_code};
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.imem_we) wq.push_back({bus.imem_addr, bus.imem_wdata});
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running");
      $fatal(1, "watchdog");
   end

   // called and returning at a negedge; a random idle gap precedes each byte
   task automatic send_byte(input logic [7:0] b);
      int n;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.rx_data = b;
      bus.rx_valid = 1'b1;
      n = 0;
      while (!bus.rx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n == 20) begin
         errors++;
         $display("FAIL rx_ready_stall: got 0 want 1 within 20 cycles");
      end
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] len);
      int n;
      n = (len == 0) ? 256 : int'(len);
      send_byte(SYNC);
      send_byte(len);
`ifdef LOADER_CHECKSUM_EN
      csum = len;
`endif
      for (int i = 0; i < n; i++) begin
         send_byte(words[i][15:8]);
         send_byte(words[i][7:0]);
`ifdef LOADER_CHECKSUM_EN
         csum = csum ^ words[i][15:8] ^ words[i][7:0];
`endif
      end
   endtask

   // closes a good frame: the correct checksum byte, or the final write cycle
   task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum);
`else
      @(negedge clk);
`endif
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (bus.rx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.rx_ready); end
      checks++;
      if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
         errors++;
         $display("FAIL reset_imem: got %h want 0", {bus.imem_we, bus.imem_addr, bus.imem_wdata});
      end
      checks++;
      if (st !== HELD) begin errors++; $display("FAIL reset_status: got %b want %b", st, HELD); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", bus.rx_ready); end
   endtask

   task automatic test_garbage();
      wq.delete();
      send_byte(8'h00);
      send_byte(8'h3C);
      words[0] = 16'h1234;
      send_frame(8'd1);
      end_frame();
      checks++;
      if (st !== DONE) begin errors++; $display("FAIL garbage_status: got %b want %b", st, DONE); end
      checks++;
      if (wq.size() != 1 || wq[0] !== {8'h00, 16'h1234}) begin
         errors++;
         $display("FAIL garbage_writes: got %0d writes first %h want 1 write 001234", wq.size(), wq.size() ? wq[0] : '0);
      end
   endtask

   task automatic test_spec_frame();
      words[0] = 16'h0105;
      words[1] = 16'h020A;
      words[2] = 16'hF000;
      wq.delete();
      send_frame(8'd3);
      checks++;
      if (st !== HELD) begin errors++; $display("FAIL spec_held: got %b want %b", st, HELD); end
      end_frame();
      checks++;
      if (st !== DONE) begin errors++; $display("FAIL spec_done: got %b want %b", st, DONE); end
      checks++;
      if (wq.size() != 3) begin errors++; $display("FAIL spec_count: got %0d want 3", wq.size()); end
      for (int i = 0; i < wq.size() && i < 3; i++) begin
         checks++;
         if (wq[i] !== {ADDR_W'(i), words[i]}) begin
            errors++;
            $display("FAIL spec_write%0d: got %h want %h", i, wq[i], {ADDR_W'(i), words[i]});
         end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_bad_csum();
      wq.delete();
      send_frame(8'd3);
      send_byte(8'h00);
      checks++;
      if (st !== ERR_CS) begin errors++; $display("FAIL csum_err: got %b want %b", st, ERR_CS); end
      checks++;
      if (wq.size() != 3) begin errors++; $display("FAIL csum_kept_writes: got %0d want 3", wq.size()); end
      send_frame(8'd3);
      send_byte(csum);
      checks++;
      if (st !== DONE) begin errors++; $display("FAIL csum_recover: got %b want %b", st, DONE); end
   endtask
`endif

   task automatic test_timeout();
      int n;
      wq.delete();
      send_byte(SYNC);
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      n = 0;
      while (load_err !== 1'b1 && n < 2 * TIMEOUT_CYCLES) begin
         @(negedge clk);
         n++;
      end
      // one write cycle, then TIMEOUT_CYCLES idle cycles waiting for the next high byte
      checks++;
      if (n != TIMEOUT_CYCLES + 1) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles want %0d", n, TIMEOUT_CYCLES + 1);
      end
      checks++;
      if (st !== ERR_TO) begin errors++; $display("FAIL timeout_status: got %b want %b", st, ERR_TO); end
      checks++;
      if (wq.size() != 1 || wq[0] !== {8'h00, 16'h1122}) begin
         errors++;
         $display("FAIL timeout_writes: got %0d writes want 1 write 001122", wq.size());
      end
      send_byte(8'h11);
      checks++;
      if (st !== ERR_TO) begin errors++; $display("FAIL err_discard: got %b want %b", st, ERR_TO); end
   endtask

   task automatic test_max_frame();
      for (int i = 0; i < 256; i++) words[i] = 16'(i);
      wq.delete();
      send_frame(8'd0);
      end_frame();
      checks++;
      if (st !== DONE) begin errors++; $display("FAIL max_done: got %b want %b", st, DONE); end
      checks++;
      if (wq.size() != 256) begin errors++; $display("FAIL max_count: got %0d want 256", wq.size()); end
      for (int i = 0; i < wq.size() && i < 256; i++) begin
         checks++;
         if (wq[i] !== {ADDR_W'(i), 16'(i)}) begin
            errors++;
            $display("FAIL max_write%0d: got %h want %h", i, wq[i], {ADDR_W'(i), 16'(i)});
         end
      end
      checks++;
      if (bus.imem_addr !== '0) begin errors++; $display("FAIL max_wrap: got %h want 00", bus.imem_addr); end
   endtask

   task automatic test_reload();
      send_byte(SYNC);
      checks++;
      if (st !== HELD) begin errors++; $display("FAIL reload_held: got %b want %b", st, HELD); end
      send_byte(8'h04);
      send_byte(8'h77);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
         errors++;
         $display("FAIL midreset_imem: got %h want 0", {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata});
      end
      checks++;
      if (st !== HELD) begin errors++; $display("FAIL midreset_status: got %b want %b", st, HELD); end
      rst = 1'b0;
      @(negedge clk);
      wq.delete();
      // bytes without a sync marker must be discarded in IDLE
      send_byte(8'h01);
      send_byte(8'h12);
      send_byte(8'h34);
      repeat (2) @(negedge clk);
      checks++;
      if (wq.size() != 0 || st !== HELD) begin
         errors++;
         $display("FAIL midreset_idle: got %0d writes status %b want 0 writes status %b", wq.size(), st, HELD);
      end
   endtask

   task automatic test_random();
      int n;
      logic [4:0] exp;
      for (int f = 0; f < 6; f++) begin
         n = $urandom_range(1, 12);
         exp = DONE;
         for (int i = 0; i < n; i++) words[i] = 16'($urandom);
         wq.delete();
         send_frame(8'(n));
`ifdef LOADER_CHECKSUM_EN
         if ($urandom_range(0, 1) == 1) begin
            send_byte(~csum);
            exp = ERR_CS;
         end else send_byte(csum);
`else
         end_frame();
`endif
         checks++;
         if (st !== exp) begin errors++; $display("FAIL rand%0d_status: got %b want %b", f, st, exp); end
         checks++;
         if (wq.size() != n) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", f, wq.size(), n); end
         for (int i = 0; i < wq.size() && i < n; i++) begin
            checks++;
            if (wq[i] !== {ADDR_W'(i), words[i]}) begin
               errors++;
               $display("FAIL rand%0d_write%0d: got %h want %h", f, i, wq[i], {ADDR_W'(i), words[i]});
            end
         end
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data = '0;
      test_reset();
      test_garbage();
      test_spec_frame();
`ifdef LOADER_CHECKSUM_EN
      test_bad_csum();
`endif
      test_timeout();
      test_max_frame();
      test_reload();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
